// File: rtl/uart_tx_cfg.sv
// UART transmitter with per-frame parity/stop configuration and a one-entry
// holding buffer so frames can be queued back-to-back with no idle gap.
module uart_tx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done_tick
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     tick_cnt, tick_cnt_n;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
  logic                 tx_n, done_n, load, bit_end;
  logic                 hold_full;
  logic [DATA_BITS-1:0] hold_data, shreg, shreg_n;
  logic [1:0]           hold_mode;
  logic                 hold_two;
  logic                 par_en, par_bit, frame_two;

  assign s_ready = !hold_full;
  assign tx_busy = (state != S_IDLE);
  assign bit_end = tick && (tick_cnt == CNT_MAX);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a
    // signal unassigned, which would infer a latch.
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_cnt_n  = bit_cnt;
    tx_n       = tx;
    shreg_n    = shreg;
    done_n     = 1'b0;
    load       = 1'b0;

    if (state != S_IDLE && tick)
      tick_cnt_n = bit_end ? '0 : tick_cnt + 1'b1;

    case (state)
      S_IDLE: load = hold_full;
      S_START: if (bit_end) begin
        state_n   = S_DATA;
        tx_n      = shreg[0];
        bit_cnt_n = '0;
      end
      S_DATA: if (bit_end) begin
        if (bit_cnt == BIT_MAX) begin
          bit_cnt_n = '0;
          state_n   = par_en ? S_PARITY : S_STOP;
          tx_n      = par_en ? par_bit : 1'b1;
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
          shreg_n   = shreg >> 1;
          tx_n      = shreg[1];
        end
      end
      S_PARITY: if (bit_end) begin
        state_n   = S_STOP;
        tx_n      = 1'b1;
        bit_cnt_n = '0;
      end
      S_STOP: if (bit_end) begin
        if (frame_two && bit_cnt == '0) begin
          bit_cnt_n = BIT_W'(1);
        end else begin
          done_n    = 1'b1;
          bit_cnt_n = '0;
          if (hold_full) load = 1'b1;
          else begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // A load restarts bit timing from zero, overriding any coincident tick.
    if (load) begin
      state_n    = S_START;
      tx_n       = 1'b0;
      tick_cnt_n = '0;
      bit_cnt_n  = '0;
      shreg_n    = hold_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      tx           <= 1'b1;
      tx_done_tick <= 1'b0;
      hold_full    <= 1'b0;
    end else begin
      state        <= state_n;
      tick_cnt     <= tick_cnt_n;
      bit_cnt      <= bit_cnt_n;
      tx           <= tx_n;
      tx_done_tick <= done_n;
      if (s_valid && s_ready) hold_full <= 1'b1;
      else if (load)          hold_full <= 1'b0;
    end
  end

  // NOTE: payload and per-frame config registers carry no reset; they are only
  // read after a load, which is gated by the reset-cleared hold_full flag.
  always_ff @(posedge clk) begin
    if (s_valid && s_ready) begin
      hold_data <= s_data;
      hold_mode <= parity_mode;
      hold_two  <= two_stop;
    end
    shreg <= shreg_n;
    if (load) begin
      par_en    <= (hold_mode == 2'b01) || (hold_mode == 2'b10);
      par_bit   <= (^hold_data) ^ (hold_mode == 2'b10);
      frame_two <= hold_two;
    end
  end

endmodule
